// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin/lock arbiter in front of the shared ALU, with a registered issue stage and registered response.
// Latency: gnt is combinational in cycle N, the op is on the alu_* ports in N+1, and rsp_* is valid in N+2.
// Backpressure: none. One op issues per cycle and responses are strobes that cannot be stalled.
// Ports: clk/rst (synchronous active-high reset); req/lock/aluop/func/a/b per requester (0 = control unit, 1 = address/branch unit);
//        gnt0/gnt1 grants; alu_aluop/alu_func/alu_a/alu_b drive the ALU and alu_result/alu_zero come back from it;
//        rsp_valid0/rsp_valid1 owner strobes; rsp_result/rsp_zero shared response bus.
module alu_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int FUNC_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [1:0]            aluop0,
  input  logic [1:0]            aluop1,
  input  logic [FUNC_WIDTH-1:0] func0,
  input  logic [FUNC_WIDTH-1:0] func1,
  input  logic [DATA_WIDTH-1:0] a0,
  input  logic [DATA_WIDTH-1:0] a1,
  input  logic [DATA_WIDTH-1:0] b0,
  input  logic [DATA_WIDTH-1:0] b1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic [1:0]            alu_aluop,
  output logic [FUNC_WIDTH-1:0] alu_func,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid0,
  output logic                  rsp_valid1,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero
);

  // Arbitration state
  logic rr_ptr_q, rr_ptr_d;
  logic lock_vld_q, lock_vld_d;
  logic lock_own_q, lock_own_d;

  // Issue stage
  logic                  iss_vld_q, iss_vld_d;
  logic                  iss_own_q, iss_own_d;
  logic [1:0]            iss_aluop_q, iss_aluop_d;
  logic [FUNC_WIDTH-1:0] iss_func_q, iss_func_d;
  logic [DATA_WIDTH-1:0] iss_a_q, iss_a_d;
  logic [DATA_WIDTH-1:0] iss_b_q, iss_b_d;

  // Response stage
  logic                  rsp_valid0_q, rsp_valid1_q;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic                  rsp_zero_q;

  logic [1:0] req_v;
  logic       gnt_any;
  logic       win;

  assign req_v = {req1, req0};

  always_comb begin
    gnt_any = 1'b0;
    win     = 1'b0;
    if (!rst) begin
      if (lock_vld_q) begin
        // The lock owner is the only candidate. If it has dropped its request,
        // this cycle is spent releasing the lock and nobody is granted.
        if (req_v[lock_own_q]) begin
          gnt_any = 1'b1;
          win     = lock_own_q;
        end
      end else if (req0 && req1) begin
        gnt_any = 1'b1;
        win     = rr_ptr_q;
      end else if (req0) begin
        gnt_any = 1'b1;
        win     = 1'b0;
      end else if (req1) begin
        gnt_any = 1'b1;
        win     = 1'b1;
      end
    end
  end

  assign gnt0 = gnt_any & ~win;
  assign gnt1 = gnt_any &  win;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    if (gnt_any) begin
      rr_ptr_d   = ~win;
      lock_vld_d = win ? lock1 : lock0;
      lock_own_d = win;
    end else if (lock_vld_q) begin
      // A held lock with no grant means the owner's request is low, so the lock is released.
      lock_vld_d = 1'b0;
    end
  end

  // The issue register drives zeros on cycles with no grant.
  always_comb begin
    iss_vld_d   = gnt_any;
    iss_own_d   = 1'b0;
    iss_aluop_d = '0;
    iss_func_d  = '0;
    iss_a_d     = '0;
    iss_b_d     = '0;
    if (gnt_any) begin
      iss_own_d   = win;
      iss_aluop_d = win ? aluop1 : aluop0;
      iss_func_d  = win ? func1  : func0;
      iss_a_d     = win ? a1     : a0;
      iss_b_d     = win ? b1     : b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= 1'b0;
      lock_vld_q   <= 1'b0;
      lock_own_q   <= 1'b0;
      iss_vld_q    <= 1'b0;
      iss_own_q    <= 1'b0;
      iss_aluop_q  <= '0;
      iss_func_q   <= '0;
      iss_a_q      <= '0;
      iss_b_q      <= '0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_vld_q   <= lock_vld_d;
      lock_own_q   <= lock_own_d;
      iss_vld_q    <= iss_vld_d;
      iss_own_q    <= iss_own_d;
      iss_aluop_q  <= iss_aluop_d;
      iss_func_q   <= iss_func_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      rsp_valid0_q <= iss_vld_q & ~iss_own_q;
      rsp_valid1_q <= iss_vld_q &  iss_own_q;
      // The response bus keeps its last value on idle cycles.
      if (iss_vld_q) begin
        rsp_result_q <= alu_result;
        rsp_zero_q   <= alu_zero;
      end
    end
  end

  assign alu_aluop  = iss_aluop_q;
  assign alu_func   = iss_func_q;
  assign alu_a      = iss_a_q;
  assign alu_b      = iss_b_q;
  assign rsp_valid0 = rsp_valid0_q;
  assign rsp_valid1 = rsp_valid1_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter, with a behavioural ALU attached to the alu_* ports.
// Cycle N starts at a rising edge; inputs are driven 1 ns after the edge and outputs are sampled 1 ns later.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, lock0, lock1;
  logic [1:0] aluop0, aluop1;
  logic [5:0] func0, func1;
  logic [7:0] a0, a1, b0, b1;
  logic       gnt0, gnt1;
  logic [1:0] alu_aluop;
  logic [5:0] alu_func;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       rsp_valid0, rsp_valid1;
  logic [7:0] rsp_result;
  logic       rsp_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(8), .FUNC_WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .aluop0(aluop0), .aluop1(aluop1), .func0(func0), .func1(func1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .alu_aluop(alu_aluop), .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  // Behavioural ALU: 00 add, 01 sub, 10 R-type (0x20 add, 0x22 sub, 0x24 and, 0x25 or).
  always_comb begin
    alu_result = 8'h00;
    case (alu_aluop)
      2'b00: alu_result = alu_a + alu_b;
      2'b01: alu_result = alu_a - alu_b;
      2'b10: begin
        case (alu_func)
          6'h20:   alu_result = alu_a + alu_b;
          6'h22:   alu_result = alu_a - alu_b;
          6'h24:   alu_result = alu_a & alu_b;
          6'h25:   alu_result = alu_a | alu_b;
          default: alu_result = 8'h00;
        endcase
      end
      default: alu_result = 8'h00;
    endcase
  end
  assign alu_zero = (alu_result == 8'h00);

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    aluop0 = 0; aluop1 = 0; func0 = 0; func1 = 0;
    a0 = 0; a1 = 0; b0 = 0; b1 = 0;
  endtask

  // Hold reset for one edge; afterwards the bench is 1 ns into cycle 0 with rst low.
  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    req0 = 1; req1 = 1; a0 = 8'h11; b0 = 8'h22;
    #1;
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL reset_gnt: got gnt0=%b gnt1=%b exp 0 0", gnt0, gnt1);
    end
    next_cycle();
    #1;
    checks++;
    if ({alu_aluop, alu_func, alu_a, alu_b} !== 24'h0 || {rsp_valid0, rsp_valid1, rsp_zero} !== 3'b000 || rsp_result !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got aluop=%h func=%h a=%h b=%h rv0=%b rv1=%b res=%h z=%b exp all 0",
                         alu_aluop, alu_func, alu_a, alu_b, rsp_valid0, rsp_valid1, rsp_result, rsp_zero);
    end
    rst = 0;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_single_add();
    apply_reset();
    req0 = 1; aluop0 = 2'b00; a0 = 8'h05; b0 = 8'h03;
    #1;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL add_gnt: got gnt0=%b gnt1=%b exp 1 0", gnt0, gnt1);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_aluop !== 2'b00) begin
      errors++; $display("FAIL add_issue: got a=%h b=%h op=%b exp 05 03 00", alu_a, alu_b, alu_aluop);
    end
    next_cycle();
    #1;
    checks++;
    if (rsp_valid0 !== 1'b1 || rsp_valid1 !== 1'b0 || rsp_result !== 8'h08 || rsp_zero !== 1'b0) begin
      errors++; $display("FAIL add_rsp: got rv0=%b rv1=%b res=%h z=%b exp 1 0 08 0", rsp_valid0, rsp_valid1, rsp_result, rsp_zero);
    end
    next_cycle();
    #1;
    checks++;
    if (rsp_valid0 !== 1'b0 || rsp_result !== 8'h08) begin
      errors++; $display("FAIL add_strobe_hold: got rv0=%b res=%h exp 0 08", rsp_valid0, rsp_result);
    end
  endtask

  task automatic test_contention();
    logic [7:0] exp_res;
    logic       exp_g1;
    logic       exp_r1;
    apply_reset();
    req0 = 1; aluop0 = 2'b00; a0 = 8'h10; b0 = 8'h01;
    req1 = 1; aluop1 = 2'b00; a1 = 8'h20; b1 = 8'h02;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_g1 = (i % 2) == 1;
      checks++;
      if (gnt0 !== ~exp_g1 || gnt1 !== exp_g1) begin
        errors++; $display("FAIL rr_gnt[%0d]: got gnt0=%b gnt1=%b exp %b %b", i, gnt0, gnt1, ~exp_g1, exp_g1);
      end
      if (i >= 2) begin
        exp_r1  = ((i - 2) % 2) == 1;
        exp_res = exp_r1 ? 8'h22 : 8'h11;
        checks++;
        if (rsp_valid0 !== ~exp_r1 || rsp_valid1 !== exp_r1 || rsp_result !== exp_res) begin
          errors++; $display("FAIL rr_rsp[%0d]: got rv0=%b rv1=%b res=%h exp %b %b %h",
                             i, rsp_valid0, rsp_valid1, rsp_result, ~exp_r1, exp_r1, exp_res);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    apply_reset();
    req1 = 1; aluop1 = 2'b00; a1 = 8'h30; b1 = 8'h03;
    req0 = 1; aluop0 = 2'b00; a0 = 8'h04; b0 = 8'h01; lock0 = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) lock0 = 0;
      #1;
      if (i < 4) begin
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
          errors++; $display("FAIL lock_gnt[%0d]: got gnt0=%b gnt1=%b exp 1 0", i, gnt0, gnt1);
        end
      end else if (i == 4) begin
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
          errors++; $display("FAIL lock_pass: got gnt0=%b gnt1=%b exp 0 1", gnt0, gnt1);
        end
      end
      if (i >= 2) begin
        checks++;
        if (rsp_valid0 !== 1'b1 || rsp_valid1 !== 1'b0 || rsp_result !== 8'h05) begin
          errors++; $display("FAIL lock_rsp[%0d]: got rv0=%b rv1=%b res=%h exp 1 0 05", i, rsp_valid0, rsp_valid1, rsp_result);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_lock_release();
    apply_reset();
    req1 = 1; lock1 = 1; a1 = 8'h01; b1 = 8'h01;
    #1;
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL rel_take: got gnt0=%b gnt1=%b exp 0 1", gnt0, gnt1);
    end
    next_cycle();
    req0 = 1; a0 = 8'h02; b0 = 8'h02;
    #1;
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL rel_hold: got gnt0=%b gnt1=%b exp 0 1", gnt0, gnt1);
    end
    next_cycle();
    req1 = 0; lock1 = 0;
    #1;
    checks++;
    if (gnt1 !== 1'b0 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL rel_gap: got gnt0=%b gnt1=%b exp 0 0", gnt0, gnt1);
    end
    next_cycle();
    #1;
    checks++;
    if (gnt1 !== 1'b0 || gnt0 !== 1'b1) begin
      errors++; $display("FAIL rel_after: got gnt0=%b gnt1=%b exp 1 0", gnt0, gnt1);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_zero_flag();
    apply_reset();
    req1 = 1; aluop1 = 2'b01; a1 = 8'h03; b1 = 8'h03;
    next_cycle();
    idle_inputs();
    next_cycle();
    #1;
    checks++;
    if (rsp_valid1 !== 1'b1 || rsp_valid0 !== 1'b0 || rsp_result !== 8'h00 || rsp_zero !== 1'b1) begin
      errors++; $display("FAIL zero_rsp: got rv0=%b rv1=%b res=%h z=%b exp 0 1 00 1", rsp_valid0, rsp_valid1, rsp_result, rsp_zero);
    end
  endtask

  task automatic test_rtype();
    apply_reset();
    req0 = 1; aluop0 = 2'b10; func0 = 6'h24; a0 = 8'hF0; b0 = 8'h3C;
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (alu_aluop !== 2'b10 || alu_func !== 6'h24) begin
      errors++; $display("FAIL rtype_issue: got op=%b func=%h exp 10 24", alu_aluop, alu_func);
    end
    next_cycle();
    #1;
    checks++;
    if (rsp_valid0 !== 1'b1 || rsp_result !== 8'h30 || rsp_zero !== 1'b0) begin
      errors++; $display("FAIL rtype_rsp: got rv0=%b res=%h z=%b exp 1 30 0", rsp_valid0, rsp_result, rsp_zero);
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    req0 = 1; a0 = 8'h07; b0 = 8'h01;
    #1;
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++; $display("FAIL mid_gnt: got gnt0=%b exp 1", gnt0);
    end
    next_cycle();
    req0 = 0; rst = 1;
    #1;
    checks++;
    if (alu_a !== 8'h07 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL mid_inflight: got alu_a=%h gnt0=%b exp 07 0", alu_a, gnt0);
    end
    next_cycle();
    rst = 0;
    #1;
    checks++;
    if ({gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_zero} !== 5'b0 || {alu_aluop, alu_func, alu_a, alu_b} !== 24'h0 || rsp_result !== 8'h00) begin
      errors++; $display("FAIL mid_zero: got g0=%b g1=%b rv0=%b rv1=%b res=%h z=%b a=%h b=%h exp all 0",
                         gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_result, rsp_zero, alu_a, alu_b);
    end
    next_cycle();
    req0 = 1; req1 = 1;
    #1;
    checks++;
    if (rsp_valid0 !== 1'b0 || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL mid_rrptr: got rv0=%b gnt0=%b gnt1=%b exp 0 1 0", rsp_valid0, gnt0, gnt1);
    end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst = 1;
    #2;
    test_reset();
    test_single_add();
    test_contention();
    test_lock();
    test_lock_release();
    test_zero_flag();
    test_rtype();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and issue pipeline for the shared ALU and its ALU control decoder. Requester 0 is the main control unit (execute stage). Requester 1 is the address/branch unit. Both compete for the single ALU. The block picks one requester per cycle by round-robin with an optional lock, registers the winner's ALUOp/func/operands onto the ALU ports, captures the ALU result, and returns it to the owning requester with fixed latency.

## Interface
Parameters:
- DATA_WIDTH, 8, operand and result width
- FUNC_WIDTH, 6, R-type func field width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  requester wants an ALU slot; held with operands until granted
- lock0 / lock1  in  1  keep ownership for the next op after this grant
- aluop0 / aluop1  in  2  ALUOp (00 add, 01 sub, 10 R-type via func)
- func0 / func1  in  FUNC_WIDTH  func field, used only when ALUOp = 10
- a0 / a1, b0 / b1  in  DATA_WIDTH  operands
- gnt0 / gnt1  out  1  combinational grant in the current cycle; at most one high
- alu_aluop  out  2  registered ALUOp to the ALU control decoder
- alu_func  out  FUNC_WIDTH  registered func to the ALU control decoder
- alu_a / alu_b  out  DATA_WIDTH  registered operands to the ALU
- alu_result  in  DATA_WIDTH  ALU result, combinational from the alu_* ports
- alu_zero  in  1  ALU zero flag
- rsp_valid0 / rsp_valid1  out  1  one-cycle result strobe for that requester
- rsp_result  out  DATA_WIDTH  registered result (shared bus)
- rsp_zero  out  1  registered zero flag

## Operation
- **Arbitration state:**
  - rr_ptr (1 bit): the requester with priority.
  - lock_own (1 bit) and lock_vld (1 bit).
- **Grant rule when lock_vld = 0:**
  - If only one req is high, that requester wins.
  - If both are high, the rr_ptr requester wins.
  - If neither is high, no grant.
- **Grant rule when lock_vld = 1:**
  - Only requester lock_own can win.
  - The other requester is blocked even when lock_own's req is low.
- **Grant side effects at the clock edge:**
  - rr_ptr becomes the non-winner.
  - If the winner's lock is 1: lock_vld = 1 and lock_own = winner.
  - Otherwise lock_vld = 0.
- **Lock release:**
  - lock_vld also clears on any cycle where lock_own's req is low.
  - No grant is issued in that release cycle.
- **Issue stage:**
  - On a grant, the winner's aluop/func/a/b and an owner tag load into the issue register; iss_vld = 1.
  - With no grant, iss_vld = 0 and alu_aluop/alu_func/alu_a/alu_b drive 0.
- **Response stage:**
  - When iss_vld = 1, alu_result and alu_zero are captured into rsp_result and rsp_zero.
  - rsp_validN goes high for one cycle for the tagged owner.
  - When iss_vld = 0, rsp_result and rsp_zero hold their last value.
- **Back-to-back operation:** no stall and no backpressure. One op issues per cycle; consecutive grants to the same or different requesters pipeline without bubbles.
- **Width rules:** result is DATA_WIDTH bits, passed through unmodified. func is ignored by this block except for forwarding.

## Timing
- **Grant:** gnt asserts in cycle N, the same cycle the request is evaluated. The requester sees it at the edge ending cycle N and may present its next op in N+1.
- **Issue:** the alu_* ports carry the op in cycle N+1.
- **Response:**
  - rsp_validN and rsp_result are valid in cycle N+2.
  - Request-to-response latency is 2 cycles.
  - Throughput is 1 op/cycle.
- **Reset values:** gnt0/1 = 0, alu_* = 0, rsp_valid0/1 = 0, rsp_result = 0, rsp_zero = 0, rr_ptr = 0 (requester 0 priority), lock_vld = 0.
- **Reset mid-operation:** ops in the issue and response stages are discarded. No rsp_valid is produced for them after rst is released.
- **Requests during reset:** gnt stays 0 while rst = 1. Arbitration starts on the first cycle with rst = 0.
- **Simultaneous events:**
  - A lock set and the other requester's request in the same cycle: the lock wins from the next cycle onward.
  - A response for op k and the issue of op k+1 to the same requester coexist without interference.

## Test plan
- **Single add:** req0 with aluop 00, a = 0x05, b = 0x03 at cycle 0, ALU modelled in the bench.
  - Required: gnt0 in cycle 0.
  - alu_a = 0x05 and alu_b = 0x03 in cycle 1.
  - rsp_valid0 = 1 with rsp_result = 0x08 and rsp_zero = 0 in cycle 2.
- **Contention after reset:** req0 and req1 both high every cycle, ops 0x10+0x01 and 0x20+0x02.
  - Required: grants alternate 0, 1, 0, 1.
  - Responses 0x11, 0x22, 0x11, 0x22 arrive 2 cycles behind each grant, with matching rsp_valid.
- **Lock:** req0 with lock0 = 1 for 3 ops, req1 high throughout.
  - Required: gnt0 for 3 consecutive cycles.
  - The 4th op has lock0 = 0; it is granted to req0 and rr_ptr then passes priority to req1.
  - gnt1 asserts in the next cycle.
- **Lock release by dropping req:** lock owner 1 drops req1 while req0 is high.
  - Required: one cycle with no grant, then gnt0.
- **Zero flag:** req1 with aluop 01, a = 0x03, b = 0x03.
  - Required: rsp_valid1 with rsp_result = 0x00 and rsp_zero = 1 two cycles later.
- **Reset mid-flight:** grant req0 in cycle 0, assert rst in cycle 1 for one cycle.
  - Required: no rsp_valid0 in cycles 2–3.
  - All outputs are 0 in the cycle after the reset edge.
  - rr_ptr is back to 0.
